m_stage_lsu: RTL

Memory-stage load/store unit for the 5-stage MIPS pipeline. It sits downstream of the E-to-M pipeline register and consumes its outputs (`M_Instr`, `M_PC`, `M_ALU_C`, `M_RT`). It runs word, half and byte accesses against a data-memory port with a req/ack handshake, and drives `stall` back to freeze the pipeline registers (each register's enable = `~stall`) until the access completes. Load data leaves the unit aligned and extended for the M-to-W register.

---
 rtl/m_stage_lsu_pkg.sv | 17 +
 rtl/m_stage_lsu_if.sv | 12 +
 rtl/m_stage_lsu_dm_ext.sv | 18 +
 rtl/m_stage_lsu.sv | 74 +++++++
 4 files changed

// File: rtl/m_stage_lsu_pkg.sv
// m_stage_lsu_pkg: opcodes, FSM states and access-size helper shared by the M-stage LSU.
package m_stage_lsu_pkg;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SB  = 6'h28;
   typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_t;
   // 2 = word, 1 = half, 0 = byte (or not a memory op)
   function automatic logic [1:0] acc_size(input logic [5:0] op);
      return (op == OP_LW || op == OP_SW) ? 2'd2 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/m_stage_lsu_if.sv
// m_stage_lsu_if: data-memory req/ack port between the LSU (master) and memory (slave).
interface m_stage_lsu_if #(parameter int ADDR_W = 32);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
   modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/m_stage_lsu_dm_ext.sv
// dm_ext: selects the load lane by byte offset and sign/zero-extends it per load opcode.
module dm_ext
   import m_stage_lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [5:0]  i_op,
   output logic [31:0] o_res
);
   logic [7:0]  w_b;
   logic [15:0] w_h;
   assign w_b = i_word[{i_off, 3'b000} +: 8];
   assign w_h = i_off[1] ? i_word[31:16] : i_word[15:0];
   assign o_res = i_op == OP_LB  ? {{24{w_b[7]}}, w_b} :
                  i_op == OP_LBU ? {24'd0, w_b} :
                  i_op == OP_LH  ? {{16{w_h[15]}}, w_h} :
                  i_op == OP_LHU ? {16'd0, w_h} : i_word;
endmodule

// File: rtl/m_stage_lsu.sv
// m_stage_lsu: M-stage load/store unit; issues one req/ack memory access per op and
// stalls the pipeline until it completes.
module m_stage_lsu
   import m_stage_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         M_Instr,
   input  logic [31:0]         M_PC,
   input  logic [31:0]         M_ALU_C,
   input  logic [31:0]         M_RT,
   m_stage_lsu_if.master       mem,
   output logic                stall,
   output logic [31:0]         M_DM_OUT,
   output logic                exc_adel,
   output logic                exc_ades,
   output logic [31:0]         exc_pc
);
   lsu_state_t  r_state, w_next;
   logic [5:0]  w_op, r_op;
   logic [1:0]  w_size, r_off;
   logic        w_ld, w_st, w_mis, w_go, w_unused;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, r_rdata;
   assign w_op     = M_Instr[31:26];
   assign w_unused = ^M_Instr[25:0];
   assign w_ld     = w_op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
   assign w_st     = w_op inside {OP_SW, OP_SH, OP_SB};
   assign w_size   = acc_size(w_op);
   assign w_mis    = (w_size == 2'd2 && M_ALU_C[1:0] != 2'b00) || (w_size == 2'd1 && M_ALU_C[0]);
   assign exc_adel = w_ld & w_mis;
   assign exc_ades = w_st & w_mis;
   assign exc_pc   = M_PC;
   assign w_go     = (w_ld | w_st) & ~w_mis;
   assign stall    = (r_state == LSU_IDLE && w_go) || r_state == LSU_BUSY;
   assign w_be     = w_size == 2'd2 ? 4'b1111 :
                     w_size == 2'd1 ? (M_ALU_C[1] ? 4'b1100 : 4'b0011) : 4'b0001 << M_ALU_C[1:0];
   assign w_wdata  = w_size == 2'd2 ? M_RT : w_size == 2'd1 ? {2{M_RT[15:0]}} : {4{M_RT[7:0]}};
   always_comb begin
      w_next = r_state == LSU_IDLE ? (w_go ? LSU_BUSY : LSU_IDLE) :
               r_state == LSU_BUSY ? (mem.mem_ack ? LSU_DONE : LSU_BUSY) : LSU_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= LSU_IDLE;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_be    <= 4'b0000;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= 32'd0;
         r_op          <= 6'd0;
         r_off         <= 2'd0;
         r_rdata       <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == LSU_IDLE && w_go) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= w_st;
            mem.mem_addr  <= {M_ALU_C[ADDR_W-1:2], 2'b00};
            mem.mem_be    <= w_be;
            mem.mem_wdata <= w_wdata;
            r_op          <= w_op;
            r_off         <= M_ALU_C[1:0];
         end
         if (r_state == LSU_BUSY && mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            r_rdata     <= mem.mem_rdata;
         end
      end
   end
   dm_ext u_ext (.i_word(r_rdata), .i_off(r_off), .i_op(r_op), .o_res(M_DM_OUT));
endmodule
